riscv_fetch_stage: RTL and testbench

Front-end fetch stage of the dual-issue in-order RISC-V core. It owns the program counter, issues 64-bit (two-instruction) requests to instruction memory, and tags each group with its PC and branch-prediction outcome. It delivers groups to the decode stage's instruction queue through the fetch valid/accept handshake. On a resolved branch redirect from the back end, it discards every in-flight and buffered group.

---
 rtl/riscv_fetch_pkg.sv | 17 +
 rtl/riscv_fetch_buffer.sv | 123 ++++++++++++
 rtl/riscv_fetch_stage.sv | 70 +++++++
 tb/tb_riscv_fetch_stage.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg: shared constants, entry state type and group repacking for the fetch front end.
package riscv_fetch_pkg;
   localparam logic [31:0] INST_NOP      = 32'h0000_0013;
   localparam int          FETCH_GROUP_W = 64;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_PENDING,
      ST_READY
   } entry_state_e;

   // A group fetched from an odd word address only carries one useful
   // instruction (the upper word); slot1 is padded with a NOP.
   function automatic logic [FETCH_GROUP_W-1:0] repack(input logic odd, input logic [FETCH_GROUP_W-1:0] data);
      return odd ? {INST_NOP, data[63:32]} : data;
   endfunction
endpackage

// File: rtl/riscv_fetch_buffer.sv
// riscv_fetch_buffer: tagged in-order fetch FIFO with alloc/fill/read pointers and flush drop accounting.
//   i_alloc/i_alloc_pc/i_alloc_predict : new PENDING entry for an accepted memory request
//   i_resp_valid/i_resp_data           : in-order memory response
//   i_accept                           : decode pops the head group
//   i_flush                            : discard every entry, count outstanding responses to drop
//   o_can_alloc                        : room for another request (entries + drops < DEPTH)
//   o_valid/o_pc/o_inst/o_predict      : head group, outputs hold their last value when empty
module riscv_fetch_buffer
   import riscv_fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_alloc,
   input  logic [31:0]              i_alloc_pc,
   input  logic                     i_alloc_predict,
   input  logic                     i_resp_valid,
   input  logic [FETCH_GROUP_W-1:0] i_resp_data,
   input  logic                     i_accept,
   input  logic                     i_flush,
   output logic                     o_can_alloc,
   output logic                     o_valid,
   output logic [31:0]              o_pc,
   output logic [FETCH_GROUP_W-1:0] o_inst,
   output logic                     o_predict
);
   localparam int          AW   = $clog2(DEPTH);
   localparam logic [AW:0] ONE  = (AW+1)'(1);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   entry_state_e             r_state [DEPTH];
   logic [31:0]              r_pc    [DEPTH];
   logic                     r_pred  [DEPTH];
   logic                     r_odd   [DEPTH];
   logic [FETCH_GROUP_W-1:0] r_data  [DEPTH];
   logic [AW:0]              r_alloc_ptr;
   logic [AW:0]              r_fill_ptr;
   logic [AW:0]              r_rd_ptr;
   logic [AW:0]              r_drop_cnt;
   logic [31:0]              r_hold_pc;
   logic [FETCH_GROUP_W-1:0] r_hold_inst;
   logic                     r_hold_pred;

   logic [AW-1:0] w_alloc_idx;
   logic [AW-1:0] w_fill_idx;
   logic [AW-1:0] w_rd_idx;
   logic [AW:0]   w_entries;
   logic [AW:0]   w_pending;
   logic [AW:0]   w_outstanding;
   logic          w_fill;
   logic          w_drop;
   logic          w_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign w_alloc_idx   = r_alloc_ptr[AW-1:0];
   assign w_fill_idx    = r_fill_ptr[AW-1:0];
   assign w_rd_idx      = r_rd_ptr[AW-1:0];
   assign w_entries     = r_alloc_ptr - r_rd_ptr;
   assign w_pending     = r_alloc_ptr - r_fill_ptr;
   assign w_outstanding = w_pending + r_drop_cnt;

   // Responses still owed to flushed entries occupy capacity so drop_cnt stays bounded.
   assign o_can_alloc = (w_entries + r_drop_cnt) < FULL;

   assign w_drop = i_resp_valid && (r_drop_cnt != '0);
   assign w_fill = i_resp_valid && (r_drop_cnt == '0) && (w_pending != '0) && !i_flush;

   assign o_valid   = r_state[w_rd_idx] == ST_READY;
   assign w_pop     = o_valid && i_accept && !i_flush;
   assign o_pc      = o_valid ? r_pc[w_rd_idx] : r_hold_pc;
   assign o_inst    = o_valid ? repack(r_odd[w_rd_idx], r_data[w_rd_idx]) : r_hold_inst;
   assign o_predict = o_valid ? r_pred[w_rd_idx] : r_hold_pred;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alloc_ptr <= '0;
         r_fill_ptr  <= '0;
         r_rd_ptr    <= '0;
         r_drop_cnt  <= '0;
         r_hold_pc   <= '0;
         r_hold_inst <= '0;
         r_hold_pred <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_state[i] <= ST_EMPTY;
      end else begin
         r_hold_pc   <= o_pc;
         r_hold_inst <= o_inst;
         r_hold_pred <= o_predict;
         if (i_flush) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_rd_ptr    <= '0;
            // A response arriving now belongs to the oldest outstanding request and is consumed here.
            r_drop_cnt  <= w_outstanding - ((i_resp_valid && (w_outstanding != '0)) ? ONE : '0);
            for (int i = 0; i < DEPTH; i++) r_state[i] <= ST_EMPTY;
         end else begin
            if (i_alloc) begin
               r_alloc_ptr          <= r_alloc_ptr + ONE;
               r_state[w_alloc_idx] <= ST_PENDING;
            end
            if (w_fill) begin
               r_fill_ptr          <= r_fill_ptr + ONE;
               r_state[w_fill_idx] <= ST_READY;
            end
            if (w_pop) begin
               r_rd_ptr          <= r_rd_ptr + ONE;
               r_state[w_rd_idx] <= ST_EMPTY;
            end
            if (w_drop) r_drop_cnt <= r_drop_cnt - ONE;
         end
      end
   end

   // Payload needs no reset: it is only observed through READY state.
   always_ff @(posedge clk) begin
      if (i_alloc && !i_flush) begin
         r_pc[w_alloc_idx]   <= i_alloc_pc;
         r_pred[w_alloc_idx] <= i_alloc_predict;
         r_odd[w_alloc_idx]  <= i_alloc_pc[2];
      end
      if (w_fill) r_data[w_fill_idx] <= i_resp_data;
   end
endmodule

// File: rtl/riscv_fetch_stage.sv
// riscv_fetch_stage: program counter, next-pc selection and request gating of the dual-issue front end.
//   imem_req_*    : 64-bit aligned group requests to instruction memory
//   imem_resp_*   : in-order responses, never back-pressured
//   bp_*          : same-cycle branch predictor lookup on the current pc
//   branch_*      : back-end redirect, flushes every buffered and in-flight group
//   fetch_*       : head group toward decode, popped on fetch_valid & fetch_result_been_accepted
module riscv_fetch_stage
   import riscv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     imem_req_valid,
   input  logic                     imem_req_ready,
   output logic [31:0]              imem_req_addr,
   input  logic                     imem_resp_valid,
   input  logic [FETCH_GROUP_W-1:0] imem_resp_data,
   output logic [31:0]              bp_lookup_pc,
   input  logic                     bp_taken,
   input  logic [31:0]              bp_target,
   input  logic                     branch_occur,
   input  logic [31:0]              branch_target,
   output logic                     fetch_valid,
   output logic [31:0]              fetch_pc,
   output logic [FETCH_GROUP_W-1:0] fetch_inst,
   output logic                     fetch_predict_valid,
   input  logic                     fetch_result_been_accepted
);
   logic [31:0] r_pc;
   logic [31:0] w_next_pc;
   logic        w_can_alloc;
   logic        w_req_fire;

   assign imem_req_valid = !rst && !branch_occur && w_can_alloc;
   assign imem_req_addr  = {r_pc[31:3], 3'b000};
   assign bp_lookup_pc   = r_pc;
   assign w_req_fire     = imem_req_valid && imem_req_ready;

   // An odd pc fetches only its own word, so it advances by one instruction.
   always_comb w_next_pc = branch_occur ? branch_target :
                           !w_req_fire  ? r_pc :
                           bp_taken     ? bp_target :
                           r_pc + (r_pc[2] ? 32'd4 : 32'd8);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_pc <= RESET_PC;
      else     r_pc <= w_next_pc;
   end

   riscv_fetch_buffer #(
      .DEPTH(FIFO_DEPTH)
   ) u_buf (
      .clk             (clk),
      .rst             (rst),
      .i_alloc         (w_req_fire),
      .i_alloc_pc      (r_pc),
      .i_alloc_predict (bp_taken),
      .i_resp_valid    (imem_resp_valid),
      .i_resp_data     (imem_resp_data),
      .i_accept        (fetch_result_been_accepted),
      .i_flush         (branch_occur),
      .o_can_alloc     (w_can_alloc),
      .o_valid         (fetch_valid),
      .o_pc            (fetch_pc),
      .o_inst          (fetch_inst),
      .o_predict       (fetch_predict_valid)
   );
endmodule

// File: tb/tb_riscv_fetch_stage.sv
// tb_riscv_fetch_stage: scoreboard bench for riscv_fetch_stage with a fixed-latency memory model.
module tb_riscv_fetch_stage;
   import riscv_fetch_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [63:0] imem_resp_data;
   logic [31:0] bp_lookup_pc;
   logic        bp_taken;
   logic [31:0] bp_target;
   logic        branch_occur;
   logic [31:0] branch_target;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic [63:0] fetch_inst;
   logic        fetch_predict_valid;
   logic        fetch_result_been_accepted;

   riscv_fetch_stage #(
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (4)
   ) dut (
      .clk                        (clk),
      .rst                        (rst),
      .imem_req_valid             (imem_req_valid),
      .imem_req_ready             (imem_req_ready),
      .imem_req_addr              (imem_req_addr),
      .imem_resp_valid            (imem_resp_valid),
      .imem_resp_data             (imem_resp_data),
      .bp_lookup_pc               (bp_lookup_pc),
      .bp_taken                   (bp_taken),
      .bp_target                  (bp_target),
      .branch_occur               (branch_occur),
      .branch_target              (branch_target),
      .fetch_valid                (fetch_valid),
      .fetch_pc                   (fetch_pc),
      .fetch_inst                 (fetch_inst),
      .fetch_predict_valid        (fetch_predict_valid),
      .fetch_result_been_accepted (fetch_result_been_accepted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [63:0] inst;
      logic        pred;
   } grp_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   grp_t        exp_q[$];
   req_t        mem_q[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          lat = 1;
   int          n_acc, n_valid, n_pred, first_acc, first_val, rel_cyc;
   logic [31:0] model_pc, bp_at, bp_tgt;
   logic        bp_en, saw_coinc, saw100;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mw(input logic [31:0] a);
      return {a[15:0] ^ 16'hBEEF, a[15:0]};
   endfunction

   // One clock: drive memory/predictor at posedge+1, check at posedge+2, advance.
   task automatic cycle();
      grp_t        e;
      req_t        r;
      logic [31:0] a;
      if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
         r = mem_q.pop_front();
         imem_resp_valid = 1'b1;
         imem_resp_data  = {mw(r.addr + 32'd4), mw(r.addr)};
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = '0;
      end
      bp_taken  = bp_en && (bp_lookup_pc == bp_at);
      bp_target = bp_tgt;
      #1;
      check("bp_lookup_pc", 64'(bp_lookup_pc), 64'(model_pc));
      saw_coinc = branch_occur && fetch_valid && imem_resp_valid && fetch_result_been_accepted;
      if (fetch_valid) begin
         n_valid++;
         if (first_val < 0) first_val = cyc;
      end
      if (exp_q.size() == 0) check("idle_valid", 64'(fetch_valid), 64'(0));
      else if (fetch_valid && fetch_result_been_accepted && !branch_occur) begin
         e = exp_q.pop_front();
         check("fetch_pc", 64'(fetch_pc), 64'(e.pc));
         check("fetch_inst", fetch_inst, e.inst);
         check("fetch_pred", 64'(fetch_predict_valid), 64'(e.pred));
         n_pred += int'(fetch_predict_valid);
      end
      if (branch_occur) begin
         exp_q.delete();
         model_pc = branch_target;
      end else if (imem_req_valid && imem_req_ready) begin
         a = model_pc & ~32'h7;
         check("req_addr", 64'(imem_req_addr), 64'(a));
         e.pc   = model_pc;
         e.pred = bp_taken;
         e.inst = model_pc[2] ? {INST_NOP, mw(model_pc)} : {mw(a + 32'd4), mw(a)};
         exp_q.push_back(e);
         r.addr = a;
         r.due  = cyc + lat;
         mem_q.push_back(r);
         n_acc++;
         if (first_acc < 0) first_acc = cyc;
         if (a == 32'h100) saw100 = 1'b1;
         model_pc = bp_taken ? bp_tgt : model_pc + (model_pc[2] ? 32'd4 : 32'd8);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic release_rst();
      rst       = 1'b0;
      model_pc  = RST_PC;
      n_acc     = 0;
      n_valid   = 0;
      n_pred    = 0;
      first_acc = -1;
      first_val = -1;
      saw100    = 1'b0;
      rel_cyc   = cyc;
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      branch_occur    = 1'b0;
      bp_en           = 1'b0;
      bp_taken        = 1'b0;
      imem_resp_valid = 1'b0;
      mem_q.delete();
      exp_q.delete();
      @(posedge clk);
      #1;
      cyc++;
      release_rst();
   endtask

   task automatic drain();
      imem_req_ready             = 1'b0;
      fetch_result_been_accepted = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) cycle();
      check("drain", 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      imem_req_ready             = 1'b0;
      imem_resp_valid            = 1'b0;
      imem_resp_data             = '0;
      bp_taken                   = 1'b0;
      bp_target                  = '0;
      branch_occur               = 1'b0;
      branch_target              = '0;
      fetch_result_been_accepted = 1'b0;
      bp_en                      = 1'b0;
      bp_at                      = '0;
      bp_tgt                     = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_fetch_valid", 64'(fetch_valid), 64'(0));
      check("rst_fetch_pc", 64'(fetch_pc), 64'(0));
      check("rst_fetch_inst", fetch_inst, 64'(0));
      check("rst_fetch_pred", 64'(fetch_predict_valid), 64'(0));
      check("rst_req_valid", 64'(imem_req_valid), 64'(0));
      check("rst_pc", 64'(bp_lookup_pc), 64'(RST_PC));

      // Streaming: L=1, always ready, decode always accepts.
      lat = 1;
      do_reset();
      imem_req_ready             = 1'b1;
      fetch_result_been_accepted = 1'b1;
      repeat (10) cycle();
      n_valid = 0;
      repeat (10) cycle();
      check("throughput", 64'(n_valid), 64'(10));
      check("first_req_cycle", 64'(first_acc), 64'(rel_cyc));
      check("latency", 64'(first_val - first_acc), 64'(lat + 1));
      drain();

      // Decode stalled: buffer fills and pc holds.
      do_reset();
      imem_req_ready             = 1'b1;
      fetch_result_been_accepted = 1'b0;
      repeat (10) cycle();
      check("full_reqs", 64'(n_acc), 64'(4));
      check("full_req_valid", 64'(imem_req_valid), 64'(0));
      check("full_hold_pc", 64'(bp_lookup_pc), 64'(32'h20));
      drain();

      // Predicted-taken branch into an odd target.
      do_reset();
      bp_en                      = 1'b1;
      bp_at                      = 32'h10;
      bp_tgt                     = 32'h104;
      imem_req_ready             = 1'b1;
      fetch_result_been_accepted = 1'b1;
      repeat (12) cycle();
      check("bp_redirect_req", 64'(saw100), 64'(1));
      drain();
      check("bp_pred_count", 64'(n_pred), 64'(1));
      bp_en = 1'b0;

      // Redirect with long-latency requests still in flight.
      do_reset();
      lat                        = 3;
      imem_req_ready             = 1'b1;
      fetch_result_been_accepted = 1'b1;
      repeat (5) cycle();
      branch_occur  = 1'b1;
      branch_target = 32'h200;
      cycle();
      branch_occur = 1'b0;
      check("flush_valid_l3", 64'(fetch_valid), 64'(0));
      check("redirect_addr", 64'(imem_req_addr), 64'(32'h200));
      imem_req_ready = 1'b1;
      repeat (15) cycle();
      drain();

      // Redirect coinciding with accept and a response.
      do_reset();
      lat                        = 1;
      imem_req_ready             = 1'b1;
      fetch_result_been_accepted = 1'b1;
      repeat (8) cycle();
      branch_occur  = 1'b1;
      branch_target = 32'h300;
      cycle();
      branch_occur = 1'b0;
      check("coincident_flush", 64'(saw_coinc), 64'(1));
      check("flush_valid_l1", 64'(fetch_valid), 64'(0));
      repeat (10) cycle();
      drain();

      // Asynchronous reset with three groups buffered.
      do_reset();
      imem_req_ready             = 1'b1;
      fetch_result_been_accepted = 1'b0;
      for (int i = 0; i < 10 && n_acc < 3; i++) cycle();
      imem_req_ready = 1'b0;
      repeat (3) cycle();
      check("pre_rst_valid", 64'(fetch_valid), 64'(1));
      check("pre_rst_count", 64'(exp_q.size()), 64'(3));
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_valid", 64'(fetch_valid), 64'(0));
      check("async_rst_pc", 64'(fetch_pc), 64'(0));
      check("async_rst_inst", fetch_inst, 64'(0));
      check("async_rst_pred", 64'(fetch_predict_valid), 64'(0));
      check("async_rst_req", 64'(imem_req_valid), 64'(0));
      check("async_rst_lookup", 64'(bp_lookup_pc), 64'(RST_PC));
      mem_q.delete();
      exp_q.delete();
      @(posedge clk);
      #1;
      cyc++;
      release_rst();
      imem_req_ready             = 1'b1;
      fetch_result_been_accepted = 1'b1;
      repeat (10) cycle();
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
